router_ctrl: RTL and testbench

Control block for the 4-slot router payload store. Accepts packets from the packet generator over a valid/ready handshake and checks the decoded `valid_packet` flag and per-destination slot occupancy. It then pulses `write_en` into `router_datapath` to store the payload, or drops the packet. On the read side it round-robin arbitrates drain requests from the four destination consumers and frees slots as they are read.

---
 rtl/router_pkg.sv | 42 ++++
 rtl/router_rr_arb.sv | 63 ++++++
 rtl/router_ctrl.sv | 163 ++++++++++++++++
 tb/tb_router_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 4-slot router payload store control path.
//   - NUM_DEST / DEST_W      : number of destination slots and index width
//   - packet field positions : dest [1:0], type [3:2], payload [11:4]
//   - PKT_TYPE_INVALID       : type code that marks a packet as undeliverable
//   - wr_state_t             : write-side FSM state encoding
//   - dest_onehot()          : binary slot index -> one-hot slot mask
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int NUM_DEST = 4;

  // Packet field positions inside the generator's packet word.
  localparam int PKT_DEST_LSB    = 0;
  localparam int PKT_DEST_MSB    = 1;
  localparam int PKT_TYPE_LSB    = 2;
  localparam int PKT_TYPE_MSB    = 3;
  localparam int PKT_PAYLOAD_LSB = 4;
  localparam int PKT_PAYLOAD_MSB = 11;

  localparam int DEST_W = PKT_DEST_MSB - PKT_DEST_LSB + 1;

  localparam logic [PKT_TYPE_MSB-PKT_TYPE_LSB:0] PKT_TYPE_INVALID = 2'b11;

  localparam int DROP_CNT_W = 8;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DROP  = 3'd4
  } wr_state_t;

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [DEST_W-1:0] idx);
    dest_onehot      = '0;
    dest_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/router_rr_arb.sv
// -----------------------------------------------------------------------------
// router_rr_arb
// Four-way round-robin arbiter for the read (drain) side of the payload store.
// Search starts at the slot after the last granted one; the pointer resets to
// the highest index so slot 0 has first priority out of reset.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-low reset
//   i_req    in   [NUM_DEST-1:0] eligible requests (already masked by occupancy)
//   o_grant  out  [NUM_DEST-1:0] one-hot grant, combinational
//   o_sel    out  [DEST_W-1:0]   binary index of o_grant, 0 when no grant
// -----------------------------------------------------------------------------
module router_rr_arb
  import router_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_DEST-1:0] i_req,
  output logic [NUM_DEST-1:0] o_grant,
  output logic [DEST_W-1:0]   o_sel
);

  logic [DEST_W-1:0]   r_ptr;
  logic [NUM_DEST-1:0] w_rot_req;
  logic [NUM_DEST-1:0] w_grant;
  logic [DEST_W-1:0]   w_sel;
  logic                w_hit;

  // Rotate the request vector so bit 0 is the slot right after the pointer;
  // a plain lowest-bit-first scan of w_rot_req then gives round-robin order.
  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_rot
    assign w_rot_req[gi] = i_req[r_ptr + DEST_W'(gi + 1)];
  end

  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < NUM_DEST; k++) begin
      if (!w_hit && w_rot_req[k]) begin
        w_hit = 1'b1;
        w_sel = r_ptr + DEST_W'(k + 1);
      end
    end
    if (w_hit) begin
      w_grant = dest_onehot(w_sel);
    end
  end

  // Pointer only moves when a grant is actually issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= DEST_W'(NUM_DEST - 1);
    end else if (w_hit) begin
      r_ptr <= w_sel;
    end
  end

  assign o_grant = w_grant;
  assign o_sel   = w_sel;

endmodule

// File: rtl/router_ctrl.sv
// -----------------------------------------------------------------------------
// router_ctrl
// Control block for the 4-slot router payload store. The write FSM accepts one
// packet at a time from the generator, drops invalid-type packets, writes valid
// ones into their destination slot when it is empty, and waits a bounded time
// for an occupied slot to drain before dropping. The read side round-robin
// arbitrates drain requests and frees slots as they are read; both sides act
// independently in the same cycle.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous, active-low reset
//   pkt_valid     in   generator presents a packet (held until pkt_ready)
//   pkt_ready     out  packet consumed this cycle (written or dropped)
//   dest_addr     in   [1:0] destination slot of the presented packet
//   valid_packet  in   0 when the packet type field is the invalid code
//   write_en      out  store payload into slot dest_addr this cycle
//   rd_req        in   [3:0] per-slot drain requests
//   rd_valid      out  [3:0] slot occupancy flags
//   rd_grant      out  [3:0] one-hot read grant (combinational)
//   rd_sel        out  [1:0] binary index of rd_grant, 0 when idle
//   drop_cnt      out  [7:0] saturating count of dropped packets
// -----------------------------------------------------------------------------
module router_ctrl
  import router_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [DEST_W-1:0]     dest_addr,
  input  logic                  valid_packet,
  output logic                  write_en,
  input  logic [NUM_DEST-1:0]   rd_req,
  output logic [NUM_DEST-1:0]   rd_valid,
  output logic [NUM_DEST-1:0]   rd_grant,
  output logic [DEST_W-1:0]     rd_sel,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_SAT  = '1;

  wr_state_t             r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_write_en;
  logic                  r_pkt_ready;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic [NUM_DEST-1:0]   r_rd_valid;

  logic [NUM_DEST-1:0]   w_eligible;
  logic [NUM_DEST-1:0]   w_grant;
  logic [DEST_W-1:0]     w_sel;
  logic [NUM_DEST-1:0]   w_set;
  logic                  w_slot_free;

  // ---------------------------------------------------------------------------
  // Read arbitration
  // ---------------------------------------------------------------------------
  assign w_eligible = rd_req & r_rd_valid;

  router_rr_arb u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_eligible),
    .o_grant (w_grant),
    .o_sel   (w_sel)
  );

  // A slot being read this cycle is empty at the next edge, so a waiting
  // packet can go straight to WRITE without an extra idle cycle.
  assign w_slot_free = ~r_rd_valid[dest_addr] | w_grant[dest_addr];

  // ---------------------------------------------------------------------------
  // Write FSM. write_en / pkt_ready are registered alongside the state update
  // so they are exactly "state == WRITE" / "state in {WRITE, DROP}".
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_write_en  <= 1'b0;
      r_pkt_ready <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_write_en  <= 1'b0;
      r_pkt_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (pkt_valid) begin
            r_state <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (!valid_packet) begin
            r_state     <= ST_DROP;
            r_pkt_ready <= 1'b1;
          end else if (!r_rd_valid[dest_addr]) begin
            r_state     <= ST_WRITE;
            r_write_en  <= 1'b1;
            r_pkt_ready <= 1'b1;
          end else begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
        end

        ST_WAIT: begin
          if (w_slot_free) begin
            r_state     <= ST_WRITE;
            r_write_en  <= 1'b1;
            r_pkt_ready <= 1'b1;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state     <= ST_DROP;
            r_pkt_ready <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_WRITE: begin
          r_state <= ST_IDLE;
        end

        ST_DROP: begin
          r_state <= ST_IDLE;
          if (r_drop_cnt != DROP_SAT) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy flags. Writes only target empty slots, so set and clear of the
  // same bit never coincide; clear is applied last regardless.
  // ---------------------------------------------------------------------------
  assign w_set = r_write_en ? dest_onehot(dest_addr) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= '0;
    end else begin
      r_rd_valid <= (r_rd_valid | w_set) & ~w_grant;
    end
  end

  assign pkt_ready = r_pkt_ready;
  assign write_en  = r_write_en;
  assign rd_valid  = r_rd_valid;
  assign rd_grant  = w_grant;
  assign rd_sel    = w_sel;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_router_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl
// Directed bench for router_ctrl with hand-computed expectations. Outputs are
// sampled 2 time units after the rising edge; combinational read outputs are
// sampled 1 unit after their inputs change.
// -----------------------------------------------------------------------------
module tb_router_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_valid = 1'b0;
  logic       valid_packet = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [3:0] rd_req = 4'd0;

  logic       pkt_ready;
  logic       write_en;
  logic [3:0] rd_valid;
  logic [3:0] rd_grant;
  logic [1:0] rd_sel;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  router_ctrl #(.WAIT_MAX(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .dest_addr    (dest_addr),
    .valid_packet (valid_packet),
    .write_en     (write_en),
    .rd_req       (rd_req),
    .rd_valid     (rd_valid),
    .rd_grant     (rd_grant),
    .rd_sel       (rd_sel),
    .drop_cnt     (drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Presents one packet from an IDLE cycle; lat = cycles until pkt_ready
  // (-1 on timeout). Returns in the cycle after the WRITE/DROP cycle.
  task automatic do_pkt(input logic [1:0] d, input logic vp,
                        output int lat, output logic we_seen);
    lat       = -1;
    we_seen   = 1'b0;
    dest_addr = d;
    valid_packet = vp;
    pkt_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (write_en === 1'b1) we_seen = 1'b1;
      if (pkt_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    pkt_valid = 1'b0;
    step();
    $display("pkt dest=%0d vp=%0b lat=%0d we=%0b rd_valid=%b drop_cnt=%0d",
             d, vp, lat, we_seen, rd_valid, drop_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rd_req = 4'hF;
    #3;
    n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL reset_pkt_ready got=%b want=0", pkt_ready); end
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL reset_write_en got=%b want=0", write_en); end
    n_vec++; if (rd_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rd_valid got=%b want=0000", rd_valid); end
    n_vec++; if (rd_grant !== 4'b0000) begin n_err++; $display("FAIL reset_rd_grant got=%b want=0000", rd_grant); end
    n_vec++; if (rd_sel !== 2'd0) begin n_err++; $display("FAIL reset_rd_sel got=%0d want=0", rd_sel); end
    n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    rd_req = 4'h0;
    step();
    rst = 1'b1;
    step();
    $display("reset released");
  endtask

  task automatic test_write();
    dest_addr = 2'd2;
    valid_packet = 1'b1;
    pkt_valid = 1'b1;
    step();  // cycle 1: CHECK
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL write_c1_we got=%b want=0", write_en); end
    n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL write_c1_ready got=%b want=0", pkt_ready); end
    step();  // cycle 2: WRITE
    n_vec++; if (write_en !== 1'b1) begin n_err++; $display("FAIL write_c2_we got=%b want=1", write_en); end
    n_vec++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL write_c2_ready got=%b want=1", pkt_ready); end
    n_vec++; if (rd_valid !== 4'b0000) begin n_err++; $display("FAIL write_c2_rd_valid got=%b want=0000", rd_valid); end
    pkt_valid = 1'b0;
    step();  // cycle 3: IDLE, payload visible
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL write_c3_we got=%b want=0", write_en); end
    n_vec++; if (rd_valid !== 4'b0100) begin n_err++; $display("FAIL write_c3_rd_valid got=%b want=0100", rd_valid); end
    $display("write dest=2 done rd_valid=%b", rd_valid);
  endtask

  task automatic test_drop_invalid();
    int   lat;
    logic we;
    do_pkt(2'd1, 1'b0, lat, we);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL drop_latency got=%0d want=2", lat); end
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL drop_write_en got=%b want=0", we); end
    n_vec++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL drop_cnt got=%0d want=1", drop_cnt); end
    n_vec++; if (rd_valid !== 4'b0100) begin n_err++; $display("FAIL drop_rd_valid got=%b want=0100", rd_valid); end
  endtask

  task automatic test_wait_grant();
    int   lat;
    logic we;
    do_pkt(2'd0, 1'b1, lat, we);  // fill slot 0
    n_vec++; if (rd_valid !== 4'b0101) begin n_err++; $display("FAIL wg_fill_rd_valid got=%b want=0101", rd_valid); end
    dest_addr = 2'd0;
    valid_packet = 1'b1;
    pkt_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();  // cycle 5: WAIT, count 3
    n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL wg_waiting_ready got=%b want=0", pkt_ready); end
    rd_req = 4'b0001;
    #1;
    n_vec++; if (rd_grant !== 4'b0001) begin n_err++; $display("FAIL wg_grant got=%b want=0001", rd_grant); end
    n_vec++; if (rd_sel !== 2'd0) begin n_err++; $display("FAIL wg_sel got=%0d want=0", rd_sel); end
    step();  // cycle 6: WRITE
    rd_req = 4'b0000;
    n_vec++; if (write_en !== 1'b1) begin n_err++; $display("FAIL wg_write_en got=%b want=1", write_en); end
    n_vec++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL wg_ready got=%b want=1", pkt_ready); end
    pkt_valid = 1'b0;
    step();  // cycle 7
    n_vec++; if (rd_valid !== 4'b0101) begin n_err++; $display("FAIL wg_rd_valid got=%b want=0101", rd_valid); end
    $display("wait+grant dest=0 done rd_valid=%b", rd_valid);
  endtask

  task automatic test_wait_timeout();
    int   lat;
    logic we;
    do_pkt(2'd3, 1'b1, lat, we);  // fill slot 3
    n_vec++; if (rd_valid !== 4'b1101) begin n_err++; $display("FAIL to_fill_rd_valid got=%b want=1101", rd_valid); end
    do_pkt(2'd3, 1'b1, lat, we);  // no drain: 16 WAIT cycles then DROP
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL to_latency got=%0d want=18", lat); end
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL to_write_en got=%b want=0", we); end
    n_vec++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL to_drop_cnt got=%0d want=2", drop_cnt); end
    n_vec++; if (rd_valid !== 4'b1101) begin n_err++; $display("FAIL to_rd_valid got=%b want=1101", rd_valid); end
  endtask

  task automatic test_rr_drain();
    int         lat;
    logic       we;
    logic [3:0] exp_g [0:3];
    logic [1:0] exp_s [0:3];
    logic [3:0] exp_v [0:3];
    exp_g[0] = 4'b0001; exp_s[0] = 2'd0; exp_v[0] = 4'b1110;
    exp_g[1] = 4'b0010; exp_s[1] = 2'd1; exp_v[1] = 4'b1100;
    exp_g[2] = 4'b0100; exp_s[2] = 2'd2; exp_v[2] = 4'b1000;
    exp_g[3] = 4'b1000; exp_s[3] = 2'd3; exp_v[3] = 4'b0000;
    // Fresh reset so the pointer is back at 3.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
    for (int d = 0; d < 4; d++) begin
      do_pkt(2'(d), 1'b1, lat, we);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rr_fill_latency d=%0d got=%0d want=2", d, lat); end
    end
    n_vec++; if (rd_valid !== 4'b1111) begin n_err++; $display("FAIL rr_full got=%b want=1111", rd_valid); end
    rd_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (rd_grant !== exp_g[k]) begin n_err++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, rd_grant, exp_g[k]); end
      n_vec++; if (rd_sel !== exp_s[k]) begin n_err++; $display("FAIL rr_sel k=%0d got=%0d want=%0d", k, rd_sel, exp_s[k]); end
      step();
      n_vec++; if (rd_valid !== exp_v[k]) begin n_err++; $display("FAIL rr_rd_valid k=%0d got=%b want=%b", k, rd_valid, exp_v[k]); end
      $display("rr grant=%b sel=%0d rd_valid=%b", exp_g[k], exp_s[k], rd_valid);
    end
    #1;
    n_vec++; if (rd_grant !== 4'b0000) begin n_err++; $display("FAIL rr_empty_grant got=%b want=0000", rd_grant); end
    n_vec++; if (rd_sel !== 2'd0) begin n_err++; $display("FAIL rr_empty_sel got=%0d want=0", rd_sel); end
    rd_req = 4'b0000;
  endtask

  task automatic test_saturate();
    int   lat;
    logic we;
    n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL sat_start got=%0d want=0", drop_cnt); end
    for (int i = 0; i < 300; i++) begin
      do_pkt(2'(i), 1'b0, lat, we);
      if (i == 253) begin
        n_vec++; if (drop_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254 got=%0d want=254", drop_cnt); end
      end
      if (i == 254) begin
        n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_255 got=%0d want=255", drop_cnt); end
      end
    end
    n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL sat_hold got=%0d want=255", drop_cnt); end
    n_vec++; if (rd_valid !== 4'b0000) begin n_err++; $display("FAIL sat_rd_valid got=%b want=0000", rd_valid); end
  endtask

  task automatic test_reset_mid_wait();
    int   lat;
    logic we;
    do_pkt(2'd2, 1'b1, lat, we);  // fill slot 2
    n_vec++; if (rd_valid !== 4'b0100) begin n_err++; $display("FAIL rm_fill got=%b want=0100", rd_valid); end
    dest_addr = 2'd2;
    valid_packet = 1'b1;
    pkt_valid = 1'b1;
    for (int k = 0; k < 6; k++) step();  // in WAIT
    n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL rm_waiting got=%b want=0", pkt_ready); end
    #1;
    rst = 1'b0;
    #1;
    n_vec++; if (rd_valid !== 4'b0000) begin n_err++; $display("FAIL rm_rd_valid got=%b want=0000", rd_valid); end
    n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rm_drop_cnt got=%0d want=0", drop_cnt); end
    n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL rm_write_en got=%b want=0", write_en); end
    n_vec++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready got=%b want=0", pkt_ready); end
    rd_req = 4'hF;
    #1;
    n_vec++; if (rd_grant !== 4'b0000) begin n_err++; $display("FAIL rm_grant got=%b want=0000", rd_grant); end
    n_vec++; if (rd_sel !== 2'd0) begin n_err++; $display("FAIL rm_sel got=%0d want=0", rd_sel); end
    rd_req = 4'h0;
    pkt_valid = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++; if (write_en !== 1'b0) begin n_err++; $display("FAIL rm_after_we k=%0d got=%b want=0", k, write_en); end
      n_vec++; if (rd_valid !== 4'b0000) begin n_err++; $display("FAIL rm_after_rd_valid k=%0d got=%b want=0000", k, rd_valid); end
    end
    $display("reset during WAIT done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_drop_invalid();
    test_wait_grant();
    test_wait_timeout();
    test_rr_drain();
    test_saturate();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
